instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 180 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Sequential instruction fetch front end for a synchronous-read program
// memory. The memory returns mem[addr] one clock after addr is presented.
// Fetching starts from address 0 on an i_start pulse and continues at one
// instruction per non-stalled cycle. When the fetched opcode equals HLT_OP,
// that instruction is delivered and fetching stops in HALT.
//
// Optional feature: define FETCH_CYCLE_COUNT_EN to add o_cycles, a 32-bit
// count of clocks spent in PRIME and RUN. The count includes stalled cycles.
//
// Parameters
//   B       instruction width (program memory data width)
//   W       program address width (program memory address width)
//   HLT_OP  opcode in instruction bits [B-1:B-5] that halts fetching
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   i_start   one-cycle request to begin fetching at address 0
//   i_stall   downstream not ready; hold the current instruction
//   o_addr    address to program memory
//   i_data    program memory read data
//   o_instr   registered instruction to the decoder
//   o_pc      registered address of o_instr
//   o_valid   o_instr/o_pc hold a freshly fetched instruction
//   o_halted  fetch stopped on HLT_OP
//   o_cycles  (FETCH_CYCLE_COUNT_EN only) PRIME+RUN clock count
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int         B      = 16,
    parameter int         W      = 11,
    parameter logic [4:0] HLT_OP = 5'b00000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_stall,
    output logic [W-1:0] o_addr,
    input  logic [B-1:0] i_data,
    output logic [B-1:0] o_instr,
    output logic [W-1:0] o_pc,
    output logic         o_valid,
    output logic         o_halted
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [31:0]  o_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   pc_reg, pc_next;          // next address to read
    logic [W-1:0]   fpc_reg, fpc_next;        // address whose data is on i_data
    logic [B-1:0]   instr_reg, instr_next;
    logic [W-1:0]   out_pc_reg, out_pc_next;
    logic           valid_reg, valid_next;
    logic           halted_reg, halted_next;

    logic           is_halt_op;

    assign is_halt_op = (i_data[B-1 -: 5] == HLT_OP);

    // PRIME presents fpc (address 0) so that mem[0] is on i_data during the
    // first RUN cycle, whatever address IDLE or HALT was presenting. A
    // stalled RUN cycle also re-presents fpc, so i_data stays stable.
    always_comb begin
        o_addr = pc_reg;
        if ((state_reg == PRIME) || ((state_reg == RUN) && i_stall)) begin
            o_addr = fpc_reg;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        fpc_next    = fpc_reg;
        instr_next  = instr_reg;
        out_pc_next = out_pc_reg;
        valid_next  = valid_reg;
        halted_next = halted_reg;

        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                if (i_start) begin
                    state_next = PRIME;
                    pc_next    = W'(1);
                    fpc_next   = '0;
                end
            end
            PRIME: begin
                state_next = RUN;
            end
            RUN: begin
                if (!i_stall) begin
                    instr_next  = i_data;
                    out_pc_next = fpc_reg;
                    valid_next  = 1'b1;
                    fpc_next    = pc_reg;
                    pc_next     = pc_reg + W'(1);   // wraps silently
                    if (is_halt_op) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                valid_next  = 1'b0;
                halted_next = 1'b1;
                if (i_start) begin
                    state_next  = PRIME;
                    pc_next     = W'(1);
                    fpc_next    = '0;
                    halted_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            fpc_reg    <= '0;
            instr_reg  <= '0;
            out_pc_reg <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            fpc_reg    <= fpc_next;
            instr_reg  <= instr_next;
            out_pc_reg <= out_pc_next;
            valid_reg  <= valid_next;
            halted_reg <= halted_next;
        end
    end

    assign o_instr  = instr_reg;
    assign o_pc     = out_pc_reg;
    assign o_valid  = valid_reg;
    assign o_halted = halted_reg;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] cycles_reg, cycles_next;

    // Cleared on the accepted start, counts every PRIME/RUN clock, and is
    // left untouched in IDLE and HALT.
    always_comb begin
        cycles_next = cycles_reg;
        if (((state_reg == IDLE) || (state_reg == HALT)) && i_start) begin
            cycles_next = '0;
        end else if ((state_reg == PRIME) || (state_reg == RUN)) begin
            cycles_next = cycles_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_reg <= '0;
        end else begin
            cycles_reg <= cycles_next;
        end
    end

    assign o_cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. The main instance uses the default
// parameters. A second instance with W=3 exercises address wrap. Each
// instance has its own synchronous-read program memory model. Outputs are
// sampled on the falling clock edge. "Cycle n" means the sample taken n
// rising edges after the edge that accepted i_start.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        i_start, i_stall;
    logic [10:0] o_addr;
    logic [15:0] i_data;
    logic [15:0] o_instr;
    logic [10:0] o_pc;
    logic        o_valid, o_halted;

    logic        i_start_w;
    logic [2:0]  o_addr_w;
    logic [15:0] i_data_w;
    logic [15:0] o_instr_w;
    logic [2:0]  o_pc_w;
    logic        o_valid_w, o_halted_w;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] o_cycles;
    logic [31:0] o_cycles_w;
`endif

    logic [15:0] mem   [0:2047];
    logic [15:0] mem_w [0:7];

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_stall  (i_stall),
        .o_addr   (o_addr),
        .i_data   (i_data),
        .o_instr  (o_instr),
        .o_pc     (o_pc),
        .o_valid  (o_valid),
        .o_halted (o_halted)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .o_cycles (o_cycles)
`endif
    );

    instruction_fetch #(.W(3)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start_w),
        .i_stall  (1'b0),
        .o_addr   (o_addr_w),
        .i_data   (i_data_w),
        .o_instr  (o_instr_w),
        .o_pc     (o_pc_w),
        .o_valid  (o_valid_w),
        .o_halted (o_halted_w)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .o_cycles (o_cycles_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program memories.
    always @(posedge clk) begin
        i_data   <= mem[o_addr];
        i_data_w <= mem_w[o_addr_w];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse i_start for one edge; returns at the cycle-0 sample point.
    task automatic start_main();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({o_instr, o_pc, o_valid, o_halted, o_addr} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_state: got instr=%h pc=%0d v=%b h=%b addr=%0d, want all 0",
                     o_instr, o_pc, o_valid, o_halted, o_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({o_valid, o_halted, o_addr} !== 13'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got v=%b h=%b addr=%0d, want 0/0/0",
                     o_valid, o_halted, o_addr);
        end
    endtask

    task automatic test_basic();
        logic [15:0] prog [0:3];
        prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'h3003; prog[3] = 16'h0000;
        start_main();
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_prime_valid: got %b want 0", o_valid);
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            n_checks++;
            if ({o_instr, o_pc, o_valid, o_halted} !== {prog[k-2], 11'(k-2), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_cycle%0d: got instr=%h pc=%0d v=%b h=%b, want instr=%h pc=%0d v=1 h=0",
                         k, o_instr, o_pc, o_valid, o_halted, prog[k-2], k-2);
            end
        end
        tick();
        n_checks++;
        if ({o_instr, o_pc, o_valid, o_halted} !== {16'h0000, 11'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_halt: got instr=%h pc=%0d v=%b h=%b, want 0000/3/0/1",
                     o_instr, o_pc, o_valid, o_halted);
        end
`ifdef FETCH_CYCLE_COUNT_EN
        n_checks++;
        if (o_cycles !== 32'd5) begin
            n_fail++;
            $display("FAIL basic_cycles: got %0d want 5", o_cycles);
        end
`endif
        tick();
        tick();
        n_checks++;
        if ({o_instr, o_pc, o_valid, o_halted} !== {16'h0000, 11'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_halt_frozen: got instr=%h pc=%0d v=%b h=%b, want 0000/3/0/1",
                     o_instr, o_pc, o_valid, o_halted);
        end
`ifdef FETCH_CYCLE_COUNT_EN
        n_checks++;
        if (o_cycles !== 32'd5) begin
            n_fail++;
            $display("FAIL basic_cycles_frozen: got %0d want 5", o_cycles);
        end
`endif
    endtask

    // Restart from HALT, with a two-cycle stall after the second instruction.
    task automatic test_stall();
        start_main();
        n_checks++;
        if ({o_valid, o_halted} !== 2'b00) begin
            n_fail++;
            $display("FAIL restart_halted_drop: got v=%b h=%b, want 0/0", o_valid, o_halted);
        end
        tick();
        tick();
        n_checks++;
        if ({o_instr, o_pc, o_valid} !== {16'h1001, 11'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_first: got instr=%h pc=%0d v=%b, want 1001/0/1", o_instr, o_pc, o_valid);
        end
        tick();
        i_stall = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            n_checks++;
            if ({o_instr, o_pc, o_valid} !== {16'h2002, 11'd1, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold_cycle%0d: got instr=%h pc=%0d v=%b, want 2002/1/1",
                         k, o_instr, o_pc, o_valid);
            end
            if (k == 4) begin
                n_checks++;
                if (o_addr !== 11'd2) begin
                    n_fail++;
                    $display("FAIL stall_addr_replay: got %0d want 2", o_addr);
                end
            end
            if (k < 5) tick();
        end
        i_stall = 1'b0;
        tick();
        n_checks++;
        if ({o_instr, o_pc, o_valid} !== {16'h3003, 11'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_release: got instr=%h pc=%0d v=%b, want 3003/2/1", o_instr, o_pc, o_valid);
        end
        tick();
        n_checks++;
        if ({o_instr, o_pc, o_valid, o_halted} !== {16'h0000, 11'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_last: got instr=%h pc=%0d v=%b h=%b, want 0000/3/1/0",
                     o_instr, o_pc, o_valid, o_halted);
        end
        tick();
        n_checks++;
        if ({o_valid, o_halted} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_halt: got v=%b h=%b, want 0/1", o_valid, o_halted);
        end
`ifdef FETCH_CYCLE_COUNT_EN
        n_checks++;
        if (o_cycles !== 32'd7) begin
            n_fail++;
            $display("FAIL stall_cycles: got %0d want 7", o_cycles);
        end
`endif
    endtask

    // An i_start pulse while running must neither restart nor skip.
    task automatic test_start_ignored();
        logic [15:0] prog [0:3];
        prog[0] = 16'h1001; prog[1] = 16'h2002; prog[2] = 16'h3003; prog[3] = 16'h0000;
        start_main();
        tick();
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            n_checks++;
            if ({o_instr, o_pc, o_valid} !== {prog[k-2], 11'(k-2), 1'b1}) begin
                n_fail++;
                $display("FAIL start_ignored_cycle%0d: got instr=%h pc=%0d v=%b, want instr=%h pc=%0d v=1",
                         k, o_instr, o_pc, o_valid, prog[k-2], k-2);
            end
            tick();
        end
        n_checks++;
        if (o_halted !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored_halt: got h=%b want 1", o_halted);
        end
    endtask

    // W=3 instance: o_pc runs 0..7,0,1 and o_addr wraps 7->0 without halting.
    task automatic test_wrap();
        i_start_w = 1'b1;
        tick();
        i_start_w = 1'b0;
        tick();
        for (int k = 2; k <= 11; k++) begin
            logic [2:0]  ep;
            logic [2:0]  ea;
            logic [15:0] ei;
            tick();
            ep = 3'((k - 2) % 8);
            ea = 3'(k % 8);
            ei = 16'h0800 | {13'd0, ep};
            n_checks++;
            if ({o_instr_w, o_pc_w, o_valid_w, o_halted_w, o_addr_w} !== {ei, ep, 1'b1, 1'b0, ea}) begin
                n_fail++;
                $display("FAIL wrap_cycle%0d: got instr=%h pc=%0d v=%b h=%b addr=%0d, want instr=%h pc=%0d v=1 h=0 addr=%0d",
                         k, o_instr_w, o_pc_w, o_valid_w, o_halted_w, o_addr_w, ei, ep, ea);
            end
        end
    endtask

    // Reset between clock edges mid-RUN, then a clean restart.
    task automatic test_async_reset();
        start_main();
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_instr, o_pc, o_valid, o_halted, o_addr} !== 40'd0) begin
            n_fail++;
            $display("FAIL async_reset_main: got instr=%h pc=%0d v=%b h=%b addr=%0d, want all 0",
                     o_instr, o_pc, o_valid, o_halted, o_addr);
        end
        n_checks++;
        if ({o_instr_w, o_pc_w, o_valid_w, o_addr_w} !== 23'd0) begin
            n_fail++;
            $display("FAIL async_reset_wrap: got instr=%h pc=%0d v=%b addr=%0d, want all 0",
                     o_instr_w, o_pc_w, o_valid_w, o_addr_w);
        end
`ifdef FETCH_CYCLE_COUNT_EN
        n_checks++;
        if (o_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_cycles: got %0d want 0", o_cycles);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({o_valid, o_halted} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b h=%b, want 0/0", o_valid, o_halted);
        end
        start_main();
        tick();
        tick();
        n_checks++;
        if ({o_instr, o_pc, o_valid} !== {16'h1001, 11'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_restart: got instr=%h pc=%0d v=%b, want 1001/0/1",
                     o_instr, o_pc, o_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_stall   = 1'b0;
        i_start_w = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h4444;
        mem[0] = 16'h1001;
        mem[1] = 16'h2002;
        mem[2] = 16'h3003;
        mem[3] = 16'h0000;
        for (int i = 0; i < 8; i++) mem_w[i] = 16'h0800 | 16'(i);

        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_wrap();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
